keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad by walking a low level across its columns, one column per dwell period, and sampling the rows. It debounces the result and emits one 4-bit key code with a single-cycle valid strobe per press. This is the input-side counterpart to the multiplexed seven-segment driver: that driver scans anodes out, this block scans columns out and reads rows back. Its codes load the adder operands A and B.

---
 rtl/keypad_scanner.sv | 244 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with debounce.
// Walks a single low column across the keypad once per dwell period and
// samples the synchronized rows on the last dwell cycle. Four column samples
// form one frame, classified as NONE / KEY(code) / MULTI. A frame-rate FSM
// debounces presses and releases and emits one key_valid strobe per press.
//
// Ports:
//   clock_100MHz  in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   row[3:0]      in   keypad rows, active-low, asynchronous
//   col[3:0]      out  column drive, active-low, one-hot low
//   key_code[3:0] out  last accepted key, row_index*4 + col_index
//   key_valid     out  one-cycle strobe on each accepted press
//   key_down      out  high while a key is held (PRESSED or RELEASE)
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN. When it is defined, key_valid
// re-pulses every REPEAT_FRAMES frames while a key stays held.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned REPEAT_FRAMES   = 250
) (
  input  logic       clock_100MHz,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned RW = $clog2(REPEAT_FRAMES + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  // Elaboration-time parameter range checks
  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_FRAMES must be 1..15");
  end
  if (REPEAT_FRAMES < 1) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_FRAMES must be >= 1");
  end

  logic [3:0]    r_row_s1, r_row_s2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  logic [1:0]    r_hits;       // points seen so far this frame, saturates at 2
  logic [3:0]    r_hit_code;   // code of the first point seen this frame

  logic          w_sample, w_frame_end;
  logic [2:0]    w_col_cnt;
  logic [1:0]    w_col_row;
  logic [2:0]    w_hits_sum;
  logic [1:0]    w_hits_tot;   // 0 = NONE, 1 = KEY, 2 = MULTI
  logic [3:0]    w_code_tot;

  assign w_sample    = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_frame_end = w_sample && (r_col_idx == 2'd3);

  // Classify the current column sample and merge it into the frame result
  always_comb begin
    w_col_cnt = 3'd0;
    w_col_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!r_row_s2[r]) begin
        w_col_cnt = w_col_cnt + 3'd1;
        w_col_row = 2'(r);
      end
    end
    w_hits_sum = 3'(r_hits) + w_col_cnt;
    w_hits_tot = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
    w_code_tot = (r_hits == 2'd0) ? {w_col_row, r_col_idx} : r_hit_code;
  end

  // Row synchronizer, dwell/column scan and per-frame accumulation
  always_ff @(posedge clock_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_row_s1   <= 4'b1111;
      r_row_s2   <= 4'b1111;
      r_dwell    <= '0;
      r_col_idx  <= 2'd0;
      r_col      <= 4'b1110;
      r_hits     <= 2'd0;
      r_hit_code <= 4'd0;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
      if (w_sample) begin
        r_dwell   <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        r_col     <= ~(4'b0001 << (r_col_idx + 2'd1));
        if (w_frame_end) begin
          r_hits     <= 2'd0;
          r_hit_code <= 4'd0;
        end else begin
          r_hits     <= w_hits_tot;
          r_hit_code <= w_code_tot;
        end
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  logic [1:0] r_state, w_state_nx;
  logic [3:0] r_cand, w_cand_nx;
  logic [3:0] r_match, w_match_nx;
  logic [3:0] r_key_code, w_code_nx;
  logic       r_key_valid, w_valid_nx;
  logic       r_key_down;
  logic [3:0] w_match_inc;
  logic       w_is_key, w_is_held;

  assign w_match_inc = r_match + 4'd1;
  assign w_is_key    = (w_hits_tot == 2'd1);
  assign w_is_held   = w_is_key && (w_code_tot == r_key_code);

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [RW-1:0] r_rep, w_rep_nx;
  logic [RW-1:0] w_rep_inc;
  assign w_rep_inc = r_rep + RW'(1);
`endif

  // Debounce FSM next-state and output logic, stepped at frame end only
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_match_nx = r_match;
    w_code_nx  = r_key_code;
    w_valid_nx = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rep_nx   = r_rep;
`endif
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_key) begin
            if (DEBOUNCE_FRAMES == 1) begin
              w_state_nx = S_PRESSED;
              w_code_nx  = w_code_tot;
              w_valid_nx = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              w_rep_nx   = '0;
`endif
            end else begin
              w_state_nx = S_DEBOUNCE;
              w_cand_nx  = w_code_tot;
              w_match_nx = 4'd1;
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_is_key && (w_code_tot == r_cand)) begin
            w_match_nx = w_match_inc;
            if (w_match_inc == 4'(DEBOUNCE_FRAMES)) begin
              w_state_nx = S_PRESSED;
              w_code_nx  = r_cand;
              w_valid_nx = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              w_rep_nx   = '0;
`endif
            end
          end else if (w_is_key) begin
            w_cand_nx  = w_code_tot;
            w_match_nx = 4'd1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (w_is_held) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (w_rep_inc == RW'(REPEAT_FRAMES)) begin
              w_valid_nx = 1'b1;
              w_rep_nx   = '0;
            end else begin
              w_rep_nx   = w_rep_inc;
            end
`endif
          end else begin
            w_state_nx = S_RELEASE;
            w_match_nx = 4'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_rep_nx   = '0;
`endif
          end
        end
        default: begin // S_RELEASE
          if (w_hits_tot == 2'd0) begin
            w_match_nx = w_match_inc;
            if (w_match_inc >= 4'(DEBOUNCE_FRAMES)) w_state_nx = S_IDLE;
          end else if (w_is_held) begin
            // Bounce on release: resume the held key without a new strobe
            w_state_nx = S_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_rep_nx   = '0;
`endif
          end else begin
            w_match_nx = 4'd1;
          end
        end
      endcase
    end
  end

  // FSM and output registers
  always_ff @(posedge clock_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cand      <= 4'd0;
      r_match     <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep       <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_cand      <= w_cand_nx;
      r_match     <= w_match_nx;
      r_key_code  <= w_code_nx;
      r_key_valid <= w_valid_nx;
      r_key_down  <= (w_state_nx == S_PRESSED) || (w_state_nx == S_RELEASE);
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep       <= w_rep_nx;
`endif
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized bench for keypad_scanner with a frame-level
// reference model. A keypad model turns a 16-bit "keys pressed" mask plus the
// column drive into row levels. The reference model tracks time since reset,
// looks at the key mask two edges before each column sample (synchronizer
// delay), forms frame results and applies the press/release debounce rules.
module tb_keypad_scanner;

  localparam int unsigned SD    = 4;
  localparam int unsigned DF    = 3;
  localparam int unsigned RF    = 2;
  localparam int unsigned FRAME = 4 * SD;

  localparam int P_IDLE = 0, P_DEB = 1, P_PRS = 2, P_REL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys = 16'h0;
  logic        rows_low = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int strobes  = 0;
  logic prev_valid = 1'b0;

  keypad_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF),
    .REPEAT_FRAMES   (RF)
  ) dut (
    .clock_100MHz (clk),
    .reset_n      (rst_n),
    .row          (row),
    .col          (col),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_down     (key_down)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    if (rows_low) row = 4'b0000;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          m_k = 0;         // edges since reset release
  logic [15:0] m_h1 = 16'h0, m_h2 = 16'h0;
  int          m_pts = 0;
  int          m_code1 = 0;
  int          m_ph = P_IDLE;
  int          m_cand = 0, m_cnt = 0, m_rep = 0;
  logic        exp_valid = 1'b0;
  logic [3:0]  exp_code = 4'd0;

  function automatic void accept(input int code);
    exp_code  = 4'(code);
    exp_valid = 1'b1;
    m_ph      = P_PRS;
    m_rep     = 0;
  endfunction

  // kind: 0 none, 1 single key, 2 several points
  function automatic void frame_done(input int kind, input int code);
    bit held = (kind == 1) && (code == int'(exp_code));
    case (m_ph)
      P_IDLE: if (kind == 1) begin
        if (DF == 1) accept(code);
        else begin m_cand = code; m_cnt = 1; m_ph = P_DEB; end
      end
      P_DEB: begin
        if (kind == 1 && code == m_cand) begin
          m_cnt++;
          if (m_cnt == DF) accept(m_cand);
        end else if (kind == 1) begin
          m_cand = code; m_cnt = 1;
        end else m_ph = P_IDLE;
      end
      P_PRS: begin
        if (held) begin
`ifdef KEYPAD_AUTOREPEAT_EN
          m_rep++;
          if (m_rep == RF) begin exp_valid = 1'b1; m_rep = 0; end
`endif
        end else begin
          m_ph = P_REL; m_cnt = 1; m_rep = 0;
        end
      end
      default: begin
        if (kind == 0) begin
          m_cnt++;
          if (m_cnt >= DF) m_ph = P_IDLE;
        end else if (held) begin
          m_ph = P_PRS; m_rep = 0;
        end else m_cnt = 1;
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_h1 = 16'h0; m_h2 = 16'h0; m_pts = 0; m_code1 = 0;
      m_ph = P_IDLE; m_cand = 0; m_cnt = 0; m_rep = 0;
      exp_valid = 1'b0; exp_code = 4'd0;
    end else begin
      int c;
      exp_valid = 1'b0;
      if (m_k % SD == SD - 1) begin
        c = (m_k / SD) % 4;
        for (int r = 0; r < 4; r++)
          if (m_h2[r*4+c]) begin
            if (m_pts == 0) m_code1 = r*4 + c;
            m_pts++;
          end
        if (c == 3) begin
          frame_done((m_pts > 1) ? 2 : m_pts, m_code1);
          m_pts = 0;
        end
      end
      m_h2 = m_h1;
      m_h1 = keys;
      m_k++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [3:0] exp_col;
    exp_col = ~(4'b0001 << ((m_k / SD) % 4));
    check("col", 16'(col), 16'(exp_col));
    check("key_valid", 16'(key_valid), 16'(exp_valid));
    check("key_code", 16'(key_code), 16'(exp_code));
    check("key_down", 16'(key_down), 16'((m_ph == P_PRS) || (m_ph == P_REL)));
    check("valid_twice", 16'(key_valid & prev_valid), 16'd0);
    if (key_valid) strobes++;
    prev_valid = key_valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_all();
    keys = 16'h0;
    cycles(5 * FRAME);
  endtask

  int base;
  int bounce_len;
  logic reached;

  initial begin
    // Reset with all rows pulled low
    cycles(5);
    check("rst_col", 16'(col), 16'h000e);
    check("rst_valid", 16'(key_valid), 16'd0);
    check("rst_down", 16'(key_down), 16'd0);
    check("rst_code", 16'(key_code), 16'd0);
    rst_n = 1'b1;
    rows_low = 1'b0;
    cycles($urandom_range(0, FRAME - 1));

    // Clean press of key 9 (row 2, column 1)
    base = strobes;
    keys = 16'h1 << 9;
    cycles(6 * FRAME);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("press9_strobes", 16'(strobes - base), 16'd1);
`endif
    check("press9_code", 16'(key_code), 16'd9);
    check("press9_down", 16'(key_down), 16'd1);
    release_all();
    check("release9_down", 16'(key_down), 16'd0);

    // Bouncing contact settling on key 5
    base = strobes;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i % 5 == 0) keys = (keys == 16'h0) ? (16'h1 << 5) : 16'h0;
      cycles(1);
    end
    keys = 16'h1 << 5;
    cycles(6 * FRAME);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("bounce_strobes", 16'(strobes - base), 16'd1);
`endif
    check("bounce_code", 16'(key_code), 16'd5);
    release_all();

    // Two keys at once never register
    base = strobes;
    keys = 16'h8001;
    cycles(10 * FRAME);
    check("multi_strobes", 16'(strobes - base), 16'd0);
    check("multi_code", 16'(key_code), 16'd5);
    check("multi_down", 16'(key_down), 16'd0);
    release_all();

    // Reset after two matching frames discards the debounce progress
    keys = 16'h1 << 7;
    reached = 1'b0;
    for (int i = 0; i < 5 * FRAME && !reached; i++) begin
      @(negedge clk);
      reached = (m_ph == P_DEB) && (m_cnt == 2);
    end
    check("deb_reach", 16'(reached), 16'd1);
    #1 rst_n = 1'b0;
    cycles(3);
    check("midrst_code", 16'(key_code), 16'd0);
    rst_n = 1'b1;
    base = strobes;
    cycles(3 * FRAME - 2);
    check("midrst_no_early", 16'(strobes - base), 16'd0);
    cycles(3 * FRAME);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("midrst_strobes", 16'(strobes - base), 16'd1);
`endif
    check("midrst_code7", 16'(key_code), 16'd7);
    release_all();

    // Long hold of key 3
    base = strobes;
    keys = 16'h1 << 3;
    cycles(10 * FRAME);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold3_repeats", 16'(strobes - base >= 3), 16'd1);
`else
    check("hold3_strobes", 16'(strobes - base), 16'd1);
`endif
    check("hold3_code", 16'(key_code), 16'd3);
    release_all();

    // Random traffic: idle, single keys, chords and bouncing keys
    for (int t = 0; t < 16; t++) begin
      int kind;
      int k0;
      kind = int'($urandom_range(0, 3));
      k0   = int'($urandom_range(0, 15));
      case (kind)
        0: keys = 16'h0;
        1: keys = 16'h1 << k0;
        2: keys = (16'h1 << k0) | (16'h1 << $urandom_range(0, 15));
        default: begin
          bounce_len = int'($urandom_range(2, 7));
          for (int i = 0; i < 2 * FRAME; i++) begin
            if (i % bounce_len == 0) keys = (keys == 16'h0) ? (16'h1 << k0) : 16'h0;
            cycles(1);
          end
          keys = 16'h1 << k0;
        end
      endcase
      cycles(int'($urandom_range(1, 7)) * FRAME + int'($urandom_range(0, FRAME - 1)));
    end
    release_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
